// File: rtl/exu_wb_arb_if.sv
// exu_wb_arb_if: ALU/LU result inputs, LU handshake, issue stall and register-file write port.
interface exu_wb_arb_if #(
  parameter int XLEN = 32
);
  logic            alu_wb_valid;
  logic [XLEN-1:0] alu_wb_data;
  logic [4:0]      alu_wb_rd_addr;
  logic [XLEN-1:0] alu_instr_tag;
  logic            lu_valid;
  logic            lu_ready;
  logic [XLEN-1:0] lu_data;
  logic [4:0]      lu_rd_addr;
  logic [XLEN-1:0] lu_instr_tag;
  logic            alu_issue_stall;
  logic            rf_wr_en;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic [XLEN-1:0] rf_wr_tag;
  logic            rf_wr_src;
  logic            protocol_err;
  modport master (
    output alu_wb_valid, alu_wb_data, alu_wb_rd_addr, alu_instr_tag,
    output lu_valid, lu_data, lu_rd_addr, lu_instr_tag,
    input  lu_ready, alu_issue_stall, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_tag, rf_wr_src, protocol_err
  );
  modport slave (
    input  alu_wb_valid, alu_wb_data, alu_wb_rd_addr, alu_instr_tag,
    input  lu_valid, lu_data, lu_rd_addr, lu_instr_tag,
    output lu_ready, alu_issue_stall, rf_wr_en, rf_wr_addr, rf_wr_data, rf_wr_tag, rf_wr_src, protocol_err
  );
endinterface

// File: rtl/exu_wb_arb.sv
// exu_wb_arb: shares one register-file write port between ALU (fixed priority) and LU (valid/ready, starvation-forced); ports clk, rst, bus (exu_wb_arb_if.slave).
module exu_wb_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  exu_wb_arb_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stall, stall_q;
  logic            hs, blocked, alu_v;
  logic            wr_en_q, wr_en_d, src_q, src_d, err_q, err_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d, tag_q, tag_d;
  assign alu_v   = bus.alu_wb_valid;
  assign hs      = bus.lu_valid & ~alu_v & ~rst;
  assign blocked = bus.lu_valid & ~hs;
  always_comb begin
    state_d = ~blocked ? IDLE :
              state_q == IDLE ? WAIT :
              (state_q == WAIT && cnt_q == CNT_W'(STARVE_MAX)) ? FORCE : state_q;
    stall   = (state_q == FORCE) & ~rst;
  end
  always_comb begin
    cnt_d   = ~blocked ? '0 : cnt_q == CNT_W'(STARVE_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    wr_en_d = alu_v ? |bus.alu_wb_rd_addr : hs ? |bus.lu_rd_addr : 1'b0;
    src_d   = alu_v ? 1'b0 : hs ? 1'b1 : src_q;
    addr_d  = alu_v ? bus.alu_wb_rd_addr : hs ? bus.lu_rd_addr : addr_q;
    data_d  = alu_v ? bus.alu_wb_data : hs ? bus.lu_data : data_q;
    tag_d   = alu_v ? bus.alu_instr_tag : hs ? bus.lu_instr_tag : tag_q;
    // an ALU result one cycle after a stall means IDU1 ignored the stall
    err_d   = err_q | (alu_v & stall_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      wr_en_q <= 1'b0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall;
      wr_en_q <= wr_en_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end
  assign bus.lu_ready        = hs;
  assign bus.alu_issue_stall = stall;
  assign bus.rf_wr_en        = wr_en_q;
  assign bus.rf_wr_src       = src_q;
  assign bus.rf_wr_addr      = addr_q;
  assign bus.rf_wr_data      = data_q;
  assign bus.rf_wr_tag       = tag_q;
  assign bus.protocol_err    = err_q;
endmodule
